// File: rtl/mbist_mem_pkg.sv
// Shared types and helpers for the MBIST memory responder.
// Fault entries use a fixed maximum address width so the struct is parameter-independent.
package mbist_mem_pkg;

  localparam logic [1:0] BANK0 = 2'b01;
  localparam logic [1:0] BANK1 = 2'b10;

  localparam int unsigned ADDR_MAX_W = 16;

  typedef enum logic {INIT, READY} state_e;

  typedef struct packed {
    logic                  en;
    logic [1:0]            bank;
    logic [ADDR_MAX_W-1:0] row;
    logic [ADDR_MAX_W-1:0] col_word;
    logic [7:0]            mask;
    logic [7:0]            val;
  } fault_entry_t;

  function automatic logic [7:0] apply_fault(input logic [7:0] data, input logic [7:0] mask,
                                             input logic [7:0] val);
    return (data & ~mask) | (val & mask);
  endfunction

endpackage

// File: rtl/mbist_fault_table.sv
// Programmable stuck-at fault table: entry registers, parallel address match and
// lowest-index priority select of the mask/value pair applied to read data.
module mbist_fault_table
  import mbist_mem_pkg::*;
#(
  parameter int unsigned ROW_W      = 10,
  parameter int unsigned COL_W      = 10,
  parameter int unsigned NUM_FAULTS = 8,
  parameter int unsigned IDX_W      = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flt_wr,
  input  logic [IDX_W-1:0] flt_idx,
  input  logic             flt_en,
  input  logic [1:0]       flt_bank,
  input  logic [ROW_W-1:0] flt_row,
  input  logic [COL_W-1:0] flt_col,
  input  logic [7:0]       flt_mask,
  input  logic [7:0]       flt_val,
  input  logic [1:0]       lk_bank,
  input  logic [ROW_W-1:0] lk_row,
  input  logic [COL_W-1:0] lk_col,
  output logic [7:0]       lk_mask,
  output logic [7:0]       lk_val
);

  fault_entry_t tbl_q [NUM_FAULTS];
  fault_entry_t new_entry;
  logic [ADDR_MAX_W-1:0] lk_row_x, lk_col_x;
  logic found;
  logic unused_lo;

  assign unused_lo = ^{flt_col[2:0], lk_col[2:0]};

  always_comb begin
    new_entry.en       = flt_en;
    new_entry.bank     = flt_bank;
    new_entry.row      = ADDR_MAX_W'(flt_row);
    new_entry.col_word = ADDR_MAX_W'(flt_col[COL_W-1:3]);
    new_entry.mask     = flt_mask;
    new_entry.val      = flt_val;
  end

  // Indices with no backing entry never match and are thereby ignored.
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < NUM_FAULTS; i++) begin
      if (rst) begin
        tbl_q[i] <= '0;
      end else if (flt_wr && flt_idx == IDX_W'(i)) begin
        tbl_q[i] <= new_entry;
      end
    end
  end

  assign lk_row_x = ADDR_MAX_W'(lk_row);
  assign lk_col_x = ADDR_MAX_W'(lk_col[COL_W-1:3]);

  always_comb begin
    found   = 1'b0;
    lk_mask = '0;
    lk_val  = '0;
    for (int unsigned i = 0; i < NUM_FAULTS; i++) begin
      if (!found && tbl_q[i].en && tbl_q[i].bank == lk_bank && tbl_q[i].row == lk_row_x &&
          tbl_q[i].col_word == lk_col_x) begin
        found   = 1'b1;
        lk_mask = tbl_q[i].mask;
        lk_val  = tbl_q[i].val;
      end
    end
  end

endmodule

// File: rtl/mbist_mem_responder.sv
// Memory-side responder for the MBIST port: two byte-wide banks, init sweep, error flagging.
// Optional stuck-at fault injection on reads when MBIST_MEM_FAULT_INJ_EN is defined.
module mbist_mem_responder
  import mbist_mem_pkg::*;
#(
  parameter int unsigned ROW_W      = 10,
  parameter int unsigned COL_W      = 10,
  parameter int unsigned NUM_FAULTS = 8,
  parameter logic [7:0]  INIT_VAL   = 8'h00,
  localparam int unsigned IDX_W     = (NUM_FAULTS > 1) ? $clog2(NUM_FAULTS) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ce,
  input  logic             we,
  input  logic [ROW_W-1:0] row_addr,
  input  logic [COL_W-1:0] col_addr,
  input  logic [1:0]       bank_addr,
  input  logic [7:0]       data_w,
  output logic [7:0]       data_r,
  output logic             mem_ready,
  output logic             access_err,
  output logic             flt_hit,
  input  logic             flt_wr,
  input  logic [IDX_W-1:0] flt_idx,
  input  logic             flt_en,
  input  logic [1:0]       flt_bank,
  input  logic [ROW_W-1:0] flt_row,
  input  logic [COL_W-1:0] flt_col,
  input  logic [7:0]       flt_mask,
  input  logic [7:0]       flt_val
);

  localparam int unsigned WORD_W = ROW_W + COL_W - 3;
  localparam int unsigned DEPTH  = 2 ** WORD_W;

  state_e state_q, state_d;
  logic [WORD_W-1:0] cnt_q;
  logic [7:0] mem0 [DEPTH];
  logic [7:0] mem1 [DEPTH];

  logic [WORD_W-1:0] addr;
  logic bank_ok, ready, init_we, acc_ok, wr_ok, rd_ok, acc_bad;
  logic [7:0] lk_mask, lk_val;
  logic [7:0] raw_q, mask_q, val_q;
  logic rd_q, err_rd_q, err_q;

  assign addr    = {row_addr, col_addr[COL_W-1:3]};
  assign bank_ok = (bank_addr == BANK0) || (bank_addr == BANK1);

  always_ff @(posedge clk) begin
    if (rst) state_q <= INIT;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (state_q == INIT && cnt_q == WORD_W'(DEPTH - 1)) state_d = READY;
  end

  always_comb begin
    ready   = (state_q == READY);
    init_we = (state_q == INIT);
  end

  always_ff @(posedge clk) begin
    if (rst)          cnt_q <= '0;
    else if (init_we) cnt_q <= cnt_q + WORD_W'(1);
  end

  assign acc_ok  = ce & ready & bank_ok;
  assign wr_ok   = acc_ok & we;
  assign rd_ok   = acc_ok & ~we;
  assign acc_bad = ce & ~(ready & bank_ok);

  always_ff @(posedge clk) begin
    if (init_we) begin
      mem0[cnt_q] <= INIT_VAL;
      mem1[cnt_q] <= INIT_VAL;
    end else if (wr_ok) begin
      if (bank_addr == BANK0) mem0[addr] <= data_w;
      else                    mem1[addr] <= data_w;
    end
  end

  // Fault mask/value are captured with the raw word so the table state at the read edge applies.
  always_ff @(posedge clk) begin
    if (rst) begin
      raw_q    <= '0;
      mask_q   <= '0;
      val_q    <= '0;
      rd_q     <= 1'b0;
      err_rd_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      rd_q <= rd_ok;
      if (rd_ok) begin
        raw_q    <= (bank_addr == BANK1) ? mem1[addr] : mem0[addr];
        mask_q   <= lk_mask;
        val_q    <= lk_val;
        err_rd_q <= 1'b0;
      end else if (acc_bad && !we) begin
        err_rd_q <= 1'b1;
      end
      if (acc_bad) err_q <= 1'b1;
    end
  end

`ifdef MBIST_MEM_FAULT_INJ_EN
  mbist_fault_table #(
    .ROW_W     (ROW_W),
    .COL_W     (COL_W),
    .NUM_FAULTS(NUM_FAULTS),
    .IDX_W     (IDX_W)
  ) u_fault_table (
    .clk     (clk),
    .rst     (rst),
    .flt_wr  (flt_wr),
    .flt_idx (flt_idx),
    .flt_en  (flt_en),
    .flt_bank(flt_bank),
    .flt_row (flt_row),
    .flt_col (flt_col),
    .flt_mask(flt_mask),
    .flt_val (flt_val),
    .lk_bank (bank_addr),
    .lk_row  (row_addr),
    .lk_col  (col_addr),
    .lk_mask (lk_mask),
    .lk_val  (lk_val)
  );
`else
  logic unused_flt;
  assign lk_mask    = '0;
  assign lk_val     = '0;
  assign unused_flt = ^{flt_wr, flt_idx, flt_en, flt_bank, flt_row, flt_col, flt_mask, flt_val,
                        col_addr[2:0]};
`endif

  assign data_r     = err_rd_q ? 8'hFF : apply_fault(raw_q, mask_q, val_q);
  assign flt_hit    = rd_q & (|((raw_q ^ val_q) & mask_q));
  assign mem_ready  = ready;
  assign access_err = err_q;

endmodule
